// File: rtl/sensor_frame_pkg.sv
// Shared types and constants for the sensor frame scheduler and the SPI slave.
package sensor_frame_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH, XFER} state_t;

  localparam int SLOT_Q1   = 0;
  localparam int SLOT_G1   = 1;
  localparam int SLOT_Q2   = 2;
  localparam int SLOT_G2   = 3;
  localparam int NUM_SLOTS = 4;

  localparam int FLAG_QUAT = 0;
  localparam int FLAG_GYRO = 1;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;

  // Frame words: q1 w/x/y/z, g1 x/y/z, q2 w/x/y/z, g2 x/y/z
  localparam int NUM_WORDS = 14;

  // Slot that owns a given frame word
  function automatic int word_slot(input int w);
    if (w < 4)       return SLOT_Q1;
    else if (w < 7)  return SLOT_G1;
    else if (w < 11) return SLOT_Q2;
    else             return SLOT_G2;
  endfunction
endpackage

// File: rtl/load_sync.sv
// Two-flop synchronizer for the MCU load strobe plus an edge register.
module load_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_load_s,
  output logic o_load_rise,
  output logic o_load_fall
);
  logic r_s1, r_s2, r_s3;

  // Synchronize load into clk domain and keep one delayed copy for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_load;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_load_s    = r_s2;
  assign o_load_rise = r_s2 & ~r_s3;
  assign o_load_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/sensor_frame_scheduler.sv
// Groups BNO085 update events into one frozen frame and runs the done/load
// handshake with the MCU SPI slave.
module sensor_frame_scheduler
  import sensor_frame_pkg::*;
#(
  parameter int COLLECT_CYCLES = 30000,
  parameter int ACK_TIMEOUT    = 300000
) (
  input  logic clk,
  input  logic reset,
  input  logic quat1_valid,
  input  logic gyro1_valid,
  input  logic quat2_valid,
  input  logic gyro2_valid,
  input  logic signed [15:0] quat1_w, quat1_x, quat1_y, quat1_z,
  input  logic signed [15:0] gyro1_x, gyro1_y, gyro1_z,
  input  logic signed [15:0] quat2_w, quat2_x, quat2_y, quat2_z,
  input  logic signed [15:0] gyro2_x, gyro2_y, gyro2_z,
  input  logic load,
  output logic done,
  output logic signed [15:0] frame_quat1_w, frame_quat1_x, frame_quat1_y, frame_quat1_z,
  output logic signed [15:0] frame_gyro1_x, frame_gyro1_y, frame_gyro1_z,
  output logic signed [15:0] frame_quat2_w, frame_quat2_x, frame_quat2_y, frame_quat2_z,
  output logic signed [15:0] frame_gyro2_x, frame_gyro2_y, frame_gyro2_z,
  output logic [7:0] frame_flags1,
  output logic [7:0] frame_flags2,
  output logic [7:0] frame_seq,
  output logic [7:0] overrun_count
);
  localparam int CMAX = (ACK_TIMEOUT > COLLECT_CYCLES) ? ACK_TIMEOUT : COLLECT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [NUM_SLOTS-1:0] r_valid_q, r_pend, w_evt, w_ovr, w_valid;
  logic signed [15:0] w_din [NUM_WORDS];
  logic signed [15:0] r_stg [NUM_WORDS];
  logic signed [15:0] r_frm [NUM_WORDS];
  logic r_done;
  logic [7:0] r_flags1, r_flags2, r_seq, r_ovr;
  logic [2:0] w_inc;
  logic [8:0] w_ovr_sum;
  logic w_load_s, w_rise, w_fall, w_pub, w_tmo;

  load_sync u_load_sync (
    .clk        (clk),
    .reset      (reset),
    .i_load     (load),
    .o_load_s   (w_load_s),
    .o_load_rise(w_rise),
    .o_load_fall(w_fall)
  );

  assign w_valid = {gyro2_valid, quat2_valid, gyro1_valid, quat1_valid};
  assign w_evt   = w_valid & ~r_valid_q;

  assign w_din[0]  = quat1_w;  assign w_din[1]  = quat1_x;
  assign w_din[2]  = quat1_y;  assign w_din[3]  = quat1_z;
  assign w_din[4]  = gyro1_x;  assign w_din[5]  = gyro1_y;
  assign w_din[6]  = gyro1_z;  assign w_din[7]  = quat2_w;
  assign w_din[8]  = quat2_x;  assign w_din[9]  = quat2_y;
  assign w_din[10] = quat2_z;  assign w_din[11] = gyro2_x;
  assign w_din[12] = gyro2_y;  assign w_din[13] = gyro2_z;

  assign w_pub = (r_state == COLLECT) &&
                 ((r_pend == 4'b1111) || (r_cnt == CW'(COLLECT_CYCLES - 1)));
  assign w_tmo = (r_state == PUBLISH) && !w_rise && (r_cnt == CW'(ACK_TIMEOUT - 1));

  // A sample is lost when a slot is overwritten before being published; an
  // event landing on the publish edge is not lost, the old value goes out.
  assign w_ovr = w_evt & r_pend & ~{NUM_SLOTS{w_pub}};

  // Number of overrun increments this cycle
  always_comb begin
    w_inc = {2'b0, w_tmo};
    for (int i = 0; i < NUM_SLOTS; i++) w_inc = w_inc + {2'b0, w_ovr[i]};
  end
  assign w_ovr_sum = {1'b0, r_ovr} + {6'b0, w_inc};

  // Edge detection, staging capture, pending bits and overrun counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_q <= '0;
      r_pend    <= '0;
      r_ovr     <= '0;
      for (int w = 0; w < NUM_WORDS; w++) r_stg[w] <= '0;
    end else begin
      r_valid_q <= w_valid;
      r_pend    <= (w_pub ? '0 : r_pend) | w_evt;
      r_ovr     <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
      for (int w = 0; w < NUM_WORDS; w++)
        if (w_evt[word_slot(w)]) r_stg[w] <= w_din[w];
    end
  end

  // Frame snapshot: loads only on the publish edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WORDS; w++) r_frm[w] <= '0;
    end else if (w_pub) begin
      for (int w = 0; w < NUM_WORDS; w++) r_frm[w] <= r_stg[w];
    end
  end

  // Frame sequencing and MCU handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_seq    <= '0;
      r_flags1 <= '0;
      r_flags2 <= '0;
    end else begin
      case (r_state)
        IDLE: if (|r_pend) begin
          r_state <= COLLECT;
          r_cnt   <= '0;
        end
        COLLECT: if (w_pub) begin
          r_state  <= PUBLISH;
          r_done   <= 1'b1;
          r_seq    <= r_seq + 8'd1;
          r_cnt    <= '0;
          r_flags1 <= '0;
          r_flags2 <= '0;
          r_flags1[FLAG_QUAT] <= r_pend[SLOT_Q1];
          r_flags1[FLAG_GYRO] <= r_pend[SLOT_G1];
          r_flags2[FLAG_QUAT] <= r_pend[SLOT_Q2];
          r_flags2[FLAG_GYRO] <= r_pend[SLOT_G2];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        PUBLISH: if (w_rise) begin
          r_state <= XFER;
          r_done  <= 1'b0;
        end else if (w_tmo) begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // Entered on a rise, so a low synchronized level means load dropped
        XFER: if (w_fall || !w_load_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done          = r_done;
  assign frame_flags1  = r_flags1;
  assign frame_flags2  = r_flags2;
  assign frame_seq     = r_seq;
  assign overrun_count = r_ovr;
  assign frame_quat1_w = r_frm[0];  assign frame_quat1_x = r_frm[1];
  assign frame_quat1_y = r_frm[2];  assign frame_quat1_z = r_frm[3];
  assign frame_gyro1_x = r_frm[4];  assign frame_gyro1_y = r_frm[5];
  assign frame_gyro1_z = r_frm[6];  assign frame_quat2_w = r_frm[7];
  assign frame_quat2_x = r_frm[8];  assign frame_quat2_y = r_frm[9];
  assign frame_quat2_z = r_frm[10]; assign frame_gyro2_x = r_frm[11];
  assign frame_gyro2_y = r_frm[12]; assign frame_gyro2_z = r_frm[13];
endmodule
